// File: rtl/pulse_period_checker.sv
// Receive-side watchdog for a periodic strobe: measures the spacing of pulse_in,
// locks after LOCK_N good intervals, flags early/late pulses, and latches a fault once locked.
module pulse_period_checker #(
  parameter int PERIOD = 1251,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4,
  parameter int CBITS  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             locked,
  output logic             fault,
  output logic             early_err,
  output logic             late_err,
  output logic [CBITS-1:0] last_interval,
  output logic [1:0]       state_dbg
);

  localparam int GBITS = $clog2(LOCK_N + 1);
  localparam logic [CBITS-1:0] WIN_LO = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] WIN_HI = CBITS'(PERIOD + TOL);
  localparam logic [CBITS-1:0] CNT_MAX = '1;
  localparam logic [GBITS-1:0] GOOD_MAX = GBITS'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] last_q, last_d;
  logic [GBITS-1:0] good_q, good_d;
  logic             early_q, early_d;
  logic             late_q, late_d;

  logic is_early;
  logic late_evt;

  // A pulse on the edge where cnt reaches the top of the window is still good;
  // only the absence of a pulse there (or a pulse beyond it) counts as late.
  assign is_early = (cnt_q < WIN_LO);
  assign late_evt = (!pulse_in && (cnt_q >= WIN_HI)) || (pulse_in && (cnt_q > WIN_HI));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    last_d  = last_q;
    early_d = 1'b0;
    late_d  = 1'b0;
    if (pulse_in) begin
      cnt_d = CBITS'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CBITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (late_evt) begin
          late_d  = 1'b1;
          good_d  = '0;
          state_d = IDLE;
        end else if (pulse_in) begin
          last_d = cnt_q;
          if (is_early) begin
            // A pulse held high would otherwise re-fire early_err every cycle.
            early_d = !early_q;
            good_d  = '0;
          end else if (good_q + GBITS'(1) == GOOD_MAX) begin
            good_d  = GOOD_MAX;
            state_d = LOCKED;
          end else begin
            good_d = good_q + GBITS'(1);
          end
        end
      end
      LOCKED: begin
        if (late_evt) begin
          late_d  = 1'b1;
          state_d = FAULT;
        end else if (pulse_in) begin
          last_d = cnt_q;
          if (is_early) begin
            early_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      good_q  <= '0;
      last_q  <= '0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      last_q  <= last_d;
      early_q <= early_d;
      late_q  <= late_d;
    end
  end

  assign locked        = (state_q == LOCKED);
  assign fault         = (state_q == FAULT);
  assign early_err     = early_q;
  assign late_err      = late_q;
  assign last_interval = last_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Bench for pulse_period_checker: directed scenarios plus random pulse gaps,
// checked every cycle against a time-stamp based reference model.
module tb_pulse_period_checker;

  localparam int PERIOD = 10;
  localparam int TOL    = 1;
  localparam int LOCK_N = 3;
  localparam int CBITS  = 11;
  localparam int LO     = PERIOD - TOL;
  localparam int HI     = PERIOD + TOL;

  localparam int M_IDLE  = 0;
  localparam int M_MEAS  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic             clk;
  logic             rst;
  logic             pulse_in;
  logic             locked;
  logic             fault;
  logic             early_err;
  logic             late_err;
  logic [CBITS-1:0] last_interval;
  logic [1:0]       state_dbg;

  pulse_period_checker #(
    .PERIOD(PERIOD), .TOL(TOL), .LOCK_N(LOCK_N), .CBITS(CBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pulse_in     (pulse_in),
    .locked       (locked),
    .fault        (fault),
    .early_err    (early_err),
    .late_err     (late_err),
    .last_interval(last_interval),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remembers the edge index of the last accepted pulse and
  // derives intervals by subtraction.
  int m_mode      = M_IDLE;
  int m_good      = 0;
  int m_last_iv   = 0;
  int m_pulse_cyc = 0;
  int m_cyc       = 0;
  bit m_early     = 1'b0;
  bit m_late      = 1'b0;
  bit prev_fault  = 1'b0;

  task automatic model_step(input bit r, input bit p);
    int gap;
    int mode_before;
    bit prev_e;
    prev_e  = m_early;
    m_early = 1'b0;
    m_late  = 1'b0;
    if (r) begin
      m_mode    = M_IDLE;
      m_good    = 0;
      m_last_iv = 0;
    end else begin
      mode_before = m_mode;
      gap = m_cyc - m_pulse_cyc;
      if (gap > 2047) gap = 2047;
      if (m_mode == M_IDLE) begin
        if (p) begin
          m_mode = M_MEAS;
          m_good = 0;
        end
      end else if (m_mode == M_MEAS || m_mode == M_LOCK) begin
        if ((!p && gap >= HI) || (p && gap > HI)) begin
          m_late = 1'b1;
          m_good = 0;
          m_mode = (m_mode == M_LOCK) ? M_FAULT : M_IDLE;
        end else if (p) begin
          m_last_iv = gap;
          if (gap < LO) begin
            if (m_mode == M_MEAS) begin
              m_early = !prev_e;
              m_good  = 0;
            end else begin
              m_early = 1'b1;
              m_mode  = M_FAULT;
            end
          end else if (m_mode == M_MEAS) begin
            m_good = m_good + 1;
            if (m_good == LOCK_N) m_mode = M_LOCK;
          end
        end
      end
      if (p && mode_before != M_FAULT) m_pulse_cyc = m_cyc;
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit r);
    check("locked", {31'd0, locked}, (m_mode == M_LOCK) ? 32'd1 : 32'd0);
    check("fault", {31'd0, fault}, (m_mode == M_FAULT) ? 32'd1 : 32'd0);
    check("early_err", {31'd0, early_err}, {31'd0, m_early});
    check("late_err", {31'd0, late_err}, {31'd0, m_late});
    check("last_interval", {21'd0, last_interval}, 32'(m_last_iv));
    check("state", {30'd0, state_dbg}, 32'(m_mode));
    check("inv_locked_and_fault", {31'd0, locked && fault}, 32'd0);
    check("inv_strobes_exclusive", {31'd0, early_err && late_err}, 32'd0);
    if (prev_fault && !r) check("inv_fault_sticky", {31'd0, fault}, 32'd1);
    prev_fault = fault;
  endtask

  task automatic do_cycle(input bit p, input bit r);
    pulse_in = p;
    rst      = r;
    @(posedge clk);
    model_step(r, p);
    @(negedge clk);
    check_all(r);
  endtask

  // Pulse arriving n cycles after the previous one.
  task automatic gap(input int n);
    for (int i = 1; i < n; i++) do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b0);
  endtask

  task automatic reset_for(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1);
  endtask

  initial begin
    pulse_in = 1'b0;
    rst      = 1'b1;

    // Reset state
    reset_for(3);
    check("reset_outputs", {21'd0, locked, fault, early_err, late_err, last_interval}, 32'd0);

    // Steady period-10 pulses: lock on the 4th pulse
    do_cycle(1'b1, 1'b0);
    gap(10);
    gap(10);
    check("lock_not_yet", {31'd0, locked}, 32'd0);
    gap(10);
    check("lock_at_4th", {31'd0, locked}, 32'd1);
    check("lock_interval", {21'd0, last_interval}, 32'd10);
    gap(10);
    check("locked_5th", {31'd0, locked}, 32'd1);
    check("locked_no_strobe", {30'd0, early_err, late_err}, 32'd0);

    // Early pulse while locked -> fault
    gap(8);
    check("early_strobe", {31'd0, early_err}, 32'd1);
    check("early_interval", {21'd0, last_interval}, 32'd8);
    check("early_fault", {31'd0, fault}, 32'd1);
    do_cycle(1'b0, 1'b0);
    check("early_one_cycle", {31'd0, early_err}, 32'd0);
    gap(10);
    check("fault_frozen_interval", {21'd0, last_interval}, 32'd8);

    // MEASURE then missing pulse -> late at cnt==11, back to IDLE
    reset_for(2);
    do_cycle(1'b1, 1'b0);
    gap(10);
    gap(10);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0);
    check("late_not_early", {31'd0, late_err}, 32'd0);
    do_cycle(1'b0, 1'b0);
    check("late_strobe", {31'd0, late_err}, 32'd1);
    check("late_to_idle", {30'd0, state_dbg}, 32'(M_IDLE));
    check("late_not_locked", {31'd0, locked}, 32'd0);
    do_cycle(1'b0, 1'b0);
    check("late_one_cycle", {31'd0, late_err}, 32'd0);

    // Window edges 9, 11, 10 are all good
    reset_for(1);
    do_cycle(1'b1, 1'b0);
    gap(9);
    gap(11);
    check("edge11_good", {30'd0, early_err, late_err}, 32'd0);
    check("edge11_interval", {21'd0, last_interval}, 32'd11);
    gap(10);
    check("edge_lock", {31'd0, locked}, 32'd1);

    // Pulse held during reset, then 50 quiet cycles
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      do_cycle(1'b0, 1'b0);
      check("quiet_outputs", {21'd0, locked, fault, early_err, late_err, last_interval}, 32'd0);
    end

    // Fault via late while locked, then reset and relock
    do_cycle(1'b1, 1'b0);
    gap(10);
    gap(10);
    gap(10);
    gap(13);
    check("late_fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b1);
    check("fault_cleared", {31'd0, fault}, 32'd0);
    do_cycle(1'b1, 1'b0);
    gap(10);
    gap(10);
    check("relock_not_yet", {31'd0, locked}, 32'd0);
    gap(10);
    check("relock", {31'd0, locked}, 32'd1);

    // Random gaps with occasional resets and out-of-window pulses
    for (int k = 0; k < 250; k++) begin
      int sel;
      sel = $urandom_range(0, 39);
      if (sel == 0) do_cycle(1'($urandom_range(0, 1)), 1'b1);
      else if (sel < 5) gap($urandom_range(1, 20));
      else gap($urandom_range(8, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
